// File: rtl/confreg_pkg.sv
// Shared constants and helpers for the config register block.
// Offsets are within the 64 KiB window selected by BASE_HI.
package confreg_pkg;

  localparam logic [15:0] DEF_BASE_HI   = 16'hBFAF;
  localparam logic [15:0] OFF_TIMER     = 16'hE000;
  localparam logic [15:0] OFF_TIMER_CMP = 16'hE004;
  localparam logic [15:0] OFF_LED       = 16'hF000;
  localparam logic [15:0] OFF_NUM       = 16'hF010;
  localparam logic [15:0] OFF_SWITCH    = 16'hF020;
  localparam logic [15:0] OFF_SIMU      = 16'hF030;

  function automatic logic [31:0] merge_be(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/sram_confreg_if.sv
// Data-SRAM-style access port between CPU side and confreg.
// Read data and hit flag are registered in the slave.
interface sram_confreg_if;
  logic        conf_en;
  logic [3:0]  conf_wen;
  logic [31:0] conf_addr;
  logic [31:0] conf_wdata;
  logic [31:0] conf_rdata;
  logic        conf_hit_r;

  modport master (
    output conf_en, conf_wen, conf_addr, conf_wdata,
    input  conf_rdata, conf_hit_r
  );

  modport slave (
    input  conf_en, conf_wen, conf_addr, conf_wdata,
    output conf_rdata, conf_hit_r
  );
endinterface

// File: rtl/confreg_timer.sv
// Free-running timer with byte-loadable count, compare register
// and a sticky compare interrupt cleared by any compare write.
module confreg_timer
  import confreg_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        load_en,
  input  logic [3:0]  load_be,
  input  logic [31:0] load_data,
  input  logic        cmp_en,
  output logic [31:0] timer,
  output logic [31:0] timer_cmp,
  output logic        irq
);

  // Count every cycle; a load overrides the increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      timer <= '0;
    else if (load_en)
      timer <= merge_be(timer, load_data, load_be);
    else
      timer <= timer + 32'd1;
  end

  // Compare value, byte-writable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      timer_cmp <= 32'hFFFF_FFFF;
    else if (cmp_en)
      timer_cmp <= merge_be(timer_cmp, load_data, load_be);
  end

  // Sticky match flag; a compare write clears it and wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      irq <= 1'b0;
    else if (cmp_en)
      irq <= 1'b0;
    else if (timer == timer_cmp)
      irq <= 1'b1;
  end

endmodule

// File: rtl/sram_confreg.sv
// Memory-mapped LED/NUM/switch/timer/simu registers on the
// data-SRAM port, with registered read data and hit flag.
module sram_confreg
  import confreg_pkg::*;
#(
  parameter logic [15:0] BASE_HI   = DEF_BASE_HI,
  parameter logic [31:0] SIMU_FLAG = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               resetn,
  sram_confreg_if.slave      bus,
  output logic [15:0]        led,
  output logic [31:0]        num_data,
  input  logic [7:0]         switch,
  output logic               timer_irq
);

  logic        hit, wr, rd;
  logic [13:0] word;
  logic        sel_tim, sel_cmp, sel_led;
  logic        sel_num, sel_sw, sel_simu;
  logic [7:0]  sw_s1, sw_s2;
  logic [31:0] timer, timer_cmp;
  logic [31:0] rmux, rdata_q;
  logic        hit_q;
  logic        unused_addr;

  assign hit  = bus.conf_en &&
                (bus.conf_addr[31:16] == BASE_HI);
  assign wr   = hit && (bus.conf_wen != 4'b0);
  assign rd   = hit && (bus.conf_wen == 4'b0);
  assign word = bus.conf_addr[15:2];
  assign unused_addr = ^bus.conf_addr[1:0];

  assign sel_tim  = word == OFF_TIMER[15:2];
  assign sel_cmp  = word == OFF_TIMER_CMP[15:2];
  assign sel_led  = word == OFF_LED[15:2];
  assign sel_num  = word == OFF_NUM[15:2];
  assign sel_sw   = word == OFF_SWITCH[15:2];
  assign sel_simu = word == OFF_SIMU[15:2];

  confreg_timer u_timer (
    .clk       (clk),
    .resetn    (resetn),
    .load_en   (wr && sel_tim),
    .load_be   (bus.conf_wen),
    .load_data (bus.conf_wdata),
    .cmp_en    (wr && sel_cmp),
    .timer     (timer),
    .timer_cmp (timer_cmp),
    .irq       (timer_irq)
  );

  // Two-flop synchronizer for the raw switches.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= switch;
      sw_s2 <= sw_s1;
    end
  end

  // LED (low 16 bits only) and NUM byte-lane writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led      <= '0;
      num_data <= '0;
    end else if (wr) begin
      if (sel_led)
        for (int i = 0; i < 2; i++)
          if (bus.conf_wen[i])
            led[8*i +: 8] <= bus.conf_wdata[8*i +: 8];
      if (sel_num)
        num_data <= merge_be(num_data, bus.conf_wdata,
                             bus.conf_wen);
    end
  end

  // Read mux over pre-edge register values.
  always_comb begin
    rmux = '0;
    unique case (1'b1)
      sel_tim:  rmux = timer;
      sel_cmp:  rmux = timer_cmp;
      sel_led:  rmux = {16'b0, led};
      sel_num:  rmux = num_data;
      sel_sw:   rmux = {24'b0, sw_s2};
      sel_simu: rmux = SIMU_FLAG;
      default:  rmux = '0;
    endcase
  end

  // Registered read data; writes and misses return 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      rdata_q <= rd ? rmux : 32'b0;
      hit_q   <= hit;
    end
  end

  assign bus.conf_rdata = rdata_q;
  assign bus.conf_hit_r = hit_q;

endmodule

// File: tb/tb_sram_confreg.sv
// Directed scoreboard bench for sram_confreg.
// Stimulus pushes expectations; a monitor pops and compares.
module tb_sram_confreg;

  typedef struct {
    logic        hit;
    logic [31:0] data;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] led;
  logic [31:0] num_data;
  logic [7:0]  sw;
  logic        timer_irq;
  int          total = 0;
  int          bad = 0;
  exp_t        q[$];
  exp_t        e;

  sram_confreg_if bus();

  sram_confreg dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .led       (led),
    .num_data  (num_data),
    .switch    (sw),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] A_TIM  = 32'hBFAF_E000;
  localparam logic [31:0] A_CMP  = 32'hBFAF_E004;
  localparam logic [31:0] A_LED  = 32'hBFAF_F000;
  localparam logic [31:0] A_NUM  = 32'hBFAF_F010;
  localparam logic [31:0] A_SW   = 32'hBFAF_F020;
  localparam logic [31:0] A_SIMU = 32'hBFAF_F030;

  task automatic drive(input logic en, input logic [3:0] wen,
                       input logic [31:0] addr,
                       input logic [31:0] wd,
                       input logic xh, input logic [31:0] xd,
                       input string nm);
    exp_t t;
    bus.conf_en    = en;
    bus.conf_wen   = wen;
    bus.conf_addr  = addr;
    bus.conf_wdata = wd;
    t.hit  = xh;
    t.data = xd;
    t.name = nm;
    q.push_back(t);
  endtask

  task automatic cyc(input logic en, input logic [3:0] wen,
                     input logic [31:0] addr,
                     input logic [31:0] wd,
                     input logic xh, input logic [31:0] xd,
                     input string nm);
    @(negedge clk);
    drive(en, wen, addr, wd, xh, xd, nm);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (bus.conf_hit_r !== e.hit || bus.conf_rdata !== e.data) begin
        bad++;
        $display("FAIL %s: got hit=%0b data=%h want hit=%0b data=%h",
                 e.name, bus.conf_hit_r, bus.conf_rdata,
                 e.hit, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    sw = 8'h00;
    bus.conf_en = 1'b0;
    bus.conf_wen = 4'h0;
    bus.conf_addr = '0;
    bus.conf_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", bus.conf_rdata, 32'h0);
    chk("rst_hit", {31'b0, bus.conf_hit_r}, 32'h0);
    chk("rst_led", {16'b0, led}, 32'h0);
    chk("rst_irq", {31'b0, timer_irq}, 32'h0);

    @(negedge clk);
    resetn = 1'b1;
    drive(1, 4'h0, A_TIM, 0, 1, 32'd0, "tim_start0");
    cyc(1, 4'h0, A_TIM, 0, 1, 32'd1, "tim_start1");
    cyc(1, 4'h0, A_CMP, 0, 1, 32'hFFFF_FFFF, "cmp_rst");
    cyc(1, 4'h0, A_SIMU, 0, 1, 32'hFFFF_FFFF, "simu");
    cyc(1, 4'h0, 32'hBFAE_F030, 0, 0, 32'h0, "miss");
    cyc(1, 4'hF, A_SIMU, 32'h0, 1, 32'h0, "simu_wr");
    cyc(1, 4'h0, A_SIMU, 0, 1, 32'hFFFF_FFFF, "simu_ro");

    cyc(1, 4'b0001, A_LED, 32'h1234_ABCD, 1, 32'h0, "led_wr1");
    @(posedge clk); #1;
    chk("led_byte0", {16'b0, led}, 32'h0000_00CD);
    cyc(1, 4'b1111, A_LED, 32'h1234_ABCD, 1, 32'h0, "led_wr4");
    @(posedge clk); #1;
    chk("led_full", {16'b0, led}, 32'h0000_ABCD);
    cyc(1, 4'h0, A_LED, 0, 1, 32'h0000_ABCD, "led_rd");
    cyc(0, 4'h0, 0, 0, 0, 32'h0, "idle_after_rd");

    cyc(1, 4'hF, A_TIM, 32'hFFFF_FFFE, 1, 32'h0, "tim_wr");
    cyc(1, 4'h0, A_TIM, 0, 1, 32'hFFFF_FFFE, "tim_rd0");
    cyc(1, 4'h0, A_TIM, 0, 1, 32'hFFFF_FFFF, "tim_rd1");
    cyc(1, 4'h0, A_TIM, 0, 1, 32'h0000_0000, "tim_wrap");
    cyc(1, 4'h0, A_TIM, 0, 1, 32'h0000_0001, "tim_rd3");
    @(posedge clk); #1;
    chk("irq_wrapmatch", {31'b0, timer_irq}, 32'h1);

    cyc(1, 4'hF, A_CMP, 32'd100, 1, 32'h0, "cmp_wr100");
    cyc(1, 4'hF, A_TIM, 32'd90, 1, 32'h0, "tim_wr90");
    repeat (10) cyc(0, 4'h0, 0, 0, 0, 32'h0, "idle");
    @(posedge clk); #1;
    chk("irq_pre", {31'b0, timer_irq}, 32'h0);
    cyc(1, 4'h0, A_TIM, 0, 1, 32'd100, "tim_at_cmp");
    @(posedge clk); #1;
    chk("irq_rise", {31'b0, timer_irq}, 32'h1);
    cyc(0, 4'h0, 0, 0, 0, 32'h0, "idle");
    cyc(0, 4'h0, 0, 0, 0, 32'h0, "idle");
    @(posedge clk); #1;
    chk("irq_hold", {31'b0, timer_irq}, 32'h1);
    cyc(1, 4'hF, A_CMP, 32'd200, 1, 32'h0, "cmp_wr200");
    @(posedge clk); #1;
    chk("irq_clear", {31'b0, timer_irq}, 32'h0);

    cyc(1, 4'hF, A_TIM, 32'd199, 1, 32'h0, "tim_wr199");
    cyc(0, 4'h0, 0, 0, 0, 32'h0, "idle");
    cyc(0, 4'h0, 0, 0, 0, 32'h0, "idle");
    @(posedge clk); #1;
    chk("irq_set200", {31'b0, timer_irq}, 32'h1);

    cyc(1, 4'h0, A_SW, 0, 1, 32'h0, "sw_before");
    @(negedge clk);
    sw = 8'hA5;
    drive(1, 4'h0, A_SW, 0, 1, 32'h0, "sw_rd1");
    cyc(1, 4'h0, A_SW, 0, 1, 32'h0, "sw_rd2");
    cyc(1, 4'h0, A_SW, 0, 1, 32'h0000_00A5, "sw_rd3");
    cyc(1, 4'h0, 32'hBFAF_0000, 0, 1, 32'h0, "unmapped");

    cyc(1, 4'hF, A_NUM, 32'hDEAD_BEEF, 1, 32'h0, "num_wr");
    cyc(1, 4'h0, A_NUM, 0, 1, 32'hDEAD_BEEF, "num_rd");
    cyc(1, 4'h0, A_NUM, 0, 0, 32'h0, "num_rd_rst");
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_rdata", bus.conf_rdata, 32'h0);
    chk("arst_num", num_data, 32'h0);
    chk("arst_led", {16'b0, led}, 32'h0);
    chk("arst_irq", {31'b0, timer_irq}, 32'h0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    drive(1, 4'h0, A_TIM, 0, 1, 32'd0, "tim_restart0");
    cyc(1, 4'h0, A_TIM, 0, 1, 32'd1, "tim_restart1");
    cyc(1, 4'h0, A_CMP, 0, 1, 32'hFFFF_FFFF, "cmp_after_rst");
    cyc(0, 4'h0, 0, 0, 0, 32'h0, "idle_end");

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
